// File: rtl/zbt_flowthru_responder.sv
// rtl/zbt_flowthru_responder.sv - flow-through ZBT SRAM responder backed by an on-chip array
module zbt_flowthru_responder #(
  parameter int DATA_BITS = 36,
  parameter int ADDR_BITS = 10,
  parameter int LANES     = 4
) (
  input  logic                 fpga_clk,
  input  logic                 rst_n,
  input  logic                 sram_cke_n,
  input  logic                 sram_cs_n,
  input  logic                 sram_adv_ld_n,
  input  logic                 sram_we_n,
  input  logic [ADDR_BITS-1:0] sram_addr,
  input  logic [LANES-1:0]     sram_bw_n,
  input  logic [DATA_BITS-1:0] sram_wdata,
  output logic [DATA_BITS-1:0] sram_rdata,
  output logic                 sram_rdata_oe
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    ST_DESELECT = 2'd0,
    ST_READ     = 2'd1,
    ST_WRITE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   base_q, base_d;
  logic [1:0]             beat_q, beat_d;
  logic [ADDR_BITS-1:0]   eff_addr;
  logic                   pend_valid_q;
  logic [ADDR_BITS-1:0]   pend_addr_q;
  logic [DATA_BITS-1:0]   rdata_q;
  logic                   oe_q;

  logic                   active;
  logic                   do_read;
  logic                   do_write;
  logic                   commit;
  logic [DATA_BITS-1:0]   old_word;
  logic [DATA_BITS-1:0]   commit_word;
  logic [DATA_BITS-1:0]   rd_word;

  logic [DATA_BITS-1:0]   mem [DEPTH];

  assign active        = !sram_cke_n;
  assign sram_rdata    = rdata_q;
  assign sram_rdata_oe = oe_q;

  // Command/burst state and pending write; everything freezes on an inactive edge
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DESELECT;
      base_q       <= '0;
      beat_q       <= 2'd0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else if (active) begin
      state_q      <= state_d;
      base_q       <= base_d;
      beat_q       <= beat_d;
      pend_valid_q <= do_write;
      if (do_write) begin
        pend_addr_q <= eff_addr;
      end
    end
  end

  // Next command state: load captures a new command, advance steps the beat within the aligned block
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q + 2'd1;
    if (!sram_adv_ld_n) begin
      beat_d = 2'd0;
      if (sram_cs_n) begin
        state_d = ST_DESELECT;
      end else begin
        state_d = sram_we_n ? ST_READ : ST_WRITE;
        base_d  = sram_addr;
      end
    end
    eff_addr = {base_d[ADDR_BITS-1:2], base_d[1:0] + beat_d};
  end

  // Per-edge actions: merge late write data with the old word, and forward it to a same-edge read
  always_comb begin
    do_read  = active && (state_d == ST_READ);
    do_write = active && (state_d == ST_WRITE);
    commit   = active && pend_valid_q;
    old_word = mem[pend_addr_q];
    commit_word = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (!sram_bw_n[i]) begin
        commit_word[9*i +: 9] = sram_wdata[9*i +: 9];
      end
    end
    rd_word = (commit && (pend_addr_q == eff_addr)) ? commit_word : mem[eff_addr];
  end

  // Flow-through read return; data holds and the enable drops on any non-read active edge
  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      oe_q    <= 1'b0;
    end else if (active) begin
      oe_q <= do_read;
      if (do_read) begin
        rdata_q <= rd_word;
      end
    end
  end

  // Array storage, not reset; the pending write lands on the edge its data arrives
  always_ff @(posedge fpga_clk) begin
    if (commit) begin
      mem[pend_addr_q] <= commit_word;
    end
  end

endmodule

// File: tb/tb_zbt_flowthru_responder.sv
// tb/tb_zbt_flowthru_responder.sv - scoreboard bench for the flow-through ZBT responder
module tb_zbt_flowthru_responder;

  logic        fpga_clk = 1'b0;
  logic        rst_n;
  logic        sram_cke_n;
  logic        sram_cs_n;
  logic        sram_adv_ld_n;
  logic        sram_we_n;
  logic [9:0]  sram_addr;
  logic [3:0]  sram_bw_n;
  logic [35:0] sram_wdata;
  logic [35:0] sram_rdata;
  logic        sram_rdata_oe;

  zbt_flowthru_responder #(.DATA_BITS(36), .ADDR_BITS(10), .LANES(4)) dut (
    .fpga_clk      (fpga_clk),
    .rst_n         (rst_n),
    .sram_cke_n    (sram_cke_n),
    .sram_cs_n     (sram_cs_n),
    .sram_adv_ld_n (sram_adv_ld_n),
    .sram_we_n     (sram_we_n),
    .sram_addr     (sram_addr),
    .sram_bw_n     (sram_bw_n),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata),
    .sram_rdata_oe (sram_rdata_oe)
  );

  always #5 fpga_clk = ~fpga_clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: plain array plus the burst/pending-write bookkeeping
  logic [35:0] ref_mem [1024];
  int          m_mode;      // 0 deselect, 1 read, 2 write
  int          m_base;
  int          m_beat;
  bit          m_pend;
  int          m_pend_addr;
  logic        exp_oe;
  logic [35:0] exp_rdata;
  logic [36:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] rnd36();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[35:0];
  endfunction

  function automatic void model_reset();
    m_mode    = 0;
    m_beat    = 0;
    m_pend    = 0;
    exp_oe    = 1'b0;
    exp_rdata = '0;
  endfunction

  function automatic void model_edge(logic cke_n, logic cs_n, logic adv_ld_n, logic we_n,
                                     logic [9:0] addr, logic [3:0] bw_n, logic [35:0] wdata);
    int a;
    if (!cke_n) begin
      if (m_pend) begin
        for (int i = 0; i < 4; i++)
          if (!bw_n[i]) ref_mem[m_pend_addr][9*i +: 9] = wdata[9*i +: 9];
        m_pend = 0;
      end
      if (!adv_ld_n) begin
        if (cs_n) m_mode = 0;
        else begin
          m_mode = we_n ? 1 : 2;
          m_base = int'(addr);
          m_beat = 0;
        end
      end else begin
        m_beat = (m_beat + 1) % 4;
      end
      a = (m_base & ~3) | ((m_base + m_beat) & 3);
      exp_oe = 1'b0;
      if (m_mode == 1) begin
        exp_oe    = 1'b1;
        exp_rdata = ref_mem[a];
      end else if (m_mode == 2) begin
        m_pend      = 1;
        m_pend_addr = a;
      end
    end
    exp_q.push_back({exp_oe, exp_rdata});
  endfunction

  task automatic step(input logic cke_n, input logic cs_n, input logic adv_ld_n, input logic we_n,
                      input logic [9:0] addr, input logic [3:0] bw_n, input logic [35:0] wdata);
    sram_cke_n    = cke_n;
    sram_cs_n     = cs_n;
    sram_adv_ld_n = adv_ld_n;
    sram_we_n     = we_n;
    sram_addr     = addr;
    sram_bw_n     = bw_n;
    sram_wdata    = wdata;
    model_edge(cke_n, cs_n, adv_ld_n, we_n, addr, bw_n, wdata);
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic ld_wr(input logic [9:0] a, input logic [3:0] bw, input logic [35:0] wd);
    step(1'b0, 1'b0, 1'b0, 1'b0, a, bw, wd);
  endtask

  task automatic ld_rd(input logic [9:0] a, input logic [3:0] bw, input logic [35:0] wd);
    step(1'b0, 1'b0, 1'b0, 1'b1, a, bw, wd);
  endtask

  task automatic adv(input logic [3:0] bw, input logic [35:0] wd);
    step(1'b0, 1'b0, 1'b1, 1'b1, 10'h0, bw, wd);
  endtask

  task automatic desel(input logic [3:0] bw, input logic [35:0] wd);
    step(1'b0, 1'b1, 1'b0, 1'b1, 10'h0, bw, wd);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_oe", 64'(sram_rdata_oe), 64'd0);
    chk("reset_rdata", 64'(sram_rdata), 64'd0);
    repeat (cycles) @(posedge fpga_clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every edge taken out of reset has one expected {oe, rdata} entry
  initial begin
    logic        live;
    logic        have;
    logic [36:0] e;
    forever begin
      @(posedge fpga_clk);
      live = rst_n;
      @(negedge fpga_clk);
      have = 1'b0;
      if (live) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 64'd0, 64'd1);
        end else begin
          e    = exp_q.pop_front();
          have = 1'b1;
        end
      end
      if (!rst_n) begin
        chk("mon_reset_oe", 64'(sram_rdata_oe), 64'd0);
        chk("mon_reset_rdata", 64'(sram_rdata), 64'd0);
      end else if (have) begin
        chk("sb_oe", 64'(sram_rdata_oe), 64'(e[36]));
        chk("sb_rdata", 64'(sram_rdata), 64'(e[35:0]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] prior;
    logic [9:0]  a;
    int          r;

    sram_cke_n = 1'b1; sram_cs_n = 1'b1; sram_adv_ld_n = 1'b0; sram_we_n = 1'b1;
    sram_addr = '0; sram_bw_n = '1; sram_wdata = '0;
    m_base = 0; m_pend_addr = 0;
    rst_n = 1'b0;
    model_reset();
    do_reset(2);

    // Fill the whole array with known random words via back-to-back writes
    for (int i = 0; i < 1024; i++) ld_wr(10'(i), 4'h0, rnd36());
    desel(4'h0, rnd36());

    // Single write then read
    ld_wr(10'h010, 4'h0, rnd36());
    ld_rd(10'h010, 4'h0, 36'h123456789);
    chk("plan1_rdata", 64'(sram_rdata), 64'h123456789);
    chk("plan1_oe", 64'(sram_rdata_oe), 64'd1);

    // Write burst from 0x022, read burst from 0x020
    ld_wr(10'h022, 4'h0, rnd36());
    adv(4'h0, 36'd1);
    adv(4'h0, 36'd2);
    adv(4'h0, 36'd3);
    ld_rd(10'h020, 4'h0, 36'd4);
    chk("burst_b0", 64'(sram_rdata), 64'd3);
    adv(4'h0, rnd36());
    chk("burst_b1", 64'(sram_rdata), 64'd4);
    adv(4'h0, rnd36());
    chk("burst_b2", 64'(sram_rdata), 64'd1);
    adv(4'h0, rnd36());
    chk("burst_b3", 64'(sram_rdata), 64'd2);

    // Write-after-read turnaround drops oe; then read-after-write bypass with partial lanes
    ld_wr(10'h005, 4'h0, rnd36());
    chk("turnaround_oe", 64'(sram_rdata_oe), 64'd0);
    desel(4'h0, 36'hFFFFFFFFF);
    ld_wr(10'h005, 4'h0, rnd36());
    ld_rd(10'h005, 4'b1010, 36'h0);
    chk("bypass_rdata", 64'(sram_rdata), 64'hFF803FE00);
    desel(4'hF, rnd36());

    // Top-of-array burst wraps within its block
    ld_rd(10'h3FF, 4'hF, rnd36());
    chk("wrap_oe0", 64'(sram_rdata_oe), 64'd1);
    chk("wrap_d0", 64'(sram_rdata), 64'(ref_mem[10'h3FF]));
    adv(4'hF, rnd36());
    chk("wrap_d1", 64'(sram_rdata), 64'(ref_mem[10'h3FC]));
    adv(4'hF, rnd36());
    chk("wrap_d2", 64'(sram_rdata), 64'(ref_mem[10'h3FD]));
    adv(4'hF, rnd36());
    chk("wrap_oe3", 64'(sram_rdata_oe), 64'd1);
    chk("wrap_d3", 64'(sram_rdata), 64'(ref_mem[10'h3FE]));

    // Stall between write command and its data
    ld_wr(10'h040, 4'h0, rnd36());
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 10'h040, 4'h0, rnd36());
    desel(4'h0, 36'hABC);
    ld_rd(10'h040, 4'hF, rnd36());
    chk("stall_rdata", 64'(sram_rdata), 64'hABC);

    // Reset with a write pending discards it
    prior = ref_mem[10'h050];
    ld_wr(10'h050, 4'h0, rnd36());
    do_reset(2);
    ld_rd(10'h050, 4'h0, ~prior);
    chk("rst_pending_rdata", 64'(sram_rdata), 64'(prior));

    // Randomized traffic concentrated on a small window to hit bypass and bursts
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(199);
      if (r == 0) begin
        do_reset(1 + $urandom_range(2));
      end else begin
        a = ($urandom_range(1) == 1) ? 10'(10'h100 + $urandom_range(7)) : 10'($urandom);
        step((r < 16), ($urandom_range(9) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
             a, 4'($urandom), rnd36());
      end
    end

    repeat (3) desel(4'hF, rnd36());
    @(negedge fpga_clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
